// File: rtl/apb_timer_multi.sv
// apb_timer_multi: N_TIMERS independent up-counting timers behind an APB slave.
// Per channel (PADDR[7:4]) four registers (PADDR[3:2]):
//   0 COUNT  1 CTRL {PRESC[15:8], IE_OVF, IE_CMP, ONESHOT, EN}  2 CMP  3 STATUS {OVFF, CMPF} (W1C)
// Ports:
//   HCLK, HRESET         clock, asynchronous active-high reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE   APB request
//   PRDATA/PREADY/PSLVERR              APB response (zero wait states, combinational read)
//   irq_o[N_TIMERS]                    per-channel level interrupt from registered flags
module apb_timer_multi #(
    parameter int unsigned N_TIMERS       = 2,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [N_TIMERS-1:0]       irq_o
);

    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] r_count [N_TIMERS];
    logic [CNT_WIDTH-1:0] r_cmp   [N_TIMERS];
    logic [7:0]           r_presc [N_TIMERS];
    logic [7:0]           r_pcnt  [N_TIMERS];
    logic [N_TIMERS-1:0]  r_en, r_oneshot, r_ie_cmp, r_ie_ovf, r_cmpf, r_ovff;

    logic [3:0]          w_chan;
    logic [1:0]          w_reg;
    logic                w_access, w_chan_ok, w_wr, w_rd;
    logic [N_TIMERS-1:0] w_wr_count, w_wr_ctrl, w_wr_cmp, w_wr_stat;
    logic [N_TIMERS-1:0] w_tick, w_match, w_wrap;
    logic                w_unused;

    // Address decode; channels beyond N_TIMERS are an error and never touch state
    assign w_chan    = PADDR[7:4];
    assign w_reg     = PADDR[3:2];
    assign w_access  = PSEL && PENABLE;
    assign w_chan_ok = 5'(w_chan) < 5'(N_TIMERS);
    assign w_wr      = w_access && PWRITE && w_chan_ok;
    assign w_rd      = w_access && !PWRITE && w_chan_ok;
    assign w_unused  = ^{PADDR, PWDATA};

    // Per-channel write strobes and tick events
    always_comb begin
        w_wr_count = '0;
        w_wr_ctrl  = '0;
        w_wr_cmp   = '0;
        w_wr_stat  = '0;
        w_tick     = '0;
        w_match    = '0;
        w_wrap     = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            if (w_wr && (w_chan == 4'(i))) begin
                w_wr_count[i] = (w_reg == REG_COUNT);
                w_wr_ctrl[i]  = (w_reg == REG_CTRL);
                w_wr_cmp[i]   = (w_reg == REG_CMP);
                w_wr_stat[i]  = (w_reg == REG_STATUS);
            end
            w_tick[i]  = r_en[i] && (r_pcnt[i] == r_presc[i]);
            // CMP==0 disables matching so the counter free-runs to overflow
            w_match[i] = w_tick[i] && (r_cmp[i] != '0) && (r_count[i] == r_cmp[i]);
            w_wrap[i]  = w_tick[i] && !w_match[i] && (r_count[i] == CNT_MAX);
        end
    end

    // Channel state; APB writes take priority over same-cycle tick updates
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                r_count[i] <= '0;
                r_cmp[i]   <= '0;
                r_presc[i] <= '0;
                r_pcnt[i]  <= '0;
            end
            r_en      <= '0;
            r_oneshot <= '0;
            r_ie_cmp  <= '0;
            r_ie_ovf  <= '0;
            r_cmpf    <= '0;
            r_ovff    <= '0;
        end else begin
            for (int i = 0; i < N_TIMERS; i++) begin
                if (w_wr_ctrl[i] || w_wr_cmp[i] || !r_en[i] || w_tick[i]) begin
                    r_pcnt[i] <= '0;
                end else begin
                    r_pcnt[i] <= r_pcnt[i] + 8'd1;
                end

                if (w_wr_count[i]) begin
                    r_count[i] <= PWDATA[CNT_WIDTH-1:0];
                end else if (w_wr_cmp[i] || w_match[i] || w_wrap[i]) begin
                    r_count[i] <= '0;
                end else if (w_tick[i]) begin
                    r_count[i] <= r_count[i] + CNT_WIDTH'(1);
                end

                if (w_wr_cmp[i]) begin
                    r_cmp[i] <= PWDATA[CNT_WIDTH-1:0];
                end

                if (w_wr_ctrl[i]) begin
                    r_en[i]      <= PWDATA[0];
                    r_oneshot[i] <= PWDATA[1];
                    r_ie_cmp[i]  <= PWDATA[2];
                    r_ie_ovf[i]  <= PWDATA[3];
                    r_presc[i]   <= PWDATA[15:8];
                end else if (w_match[i] && r_oneshot[i]) begin
                    r_en[i] <= 1'b0;
                end

                // A set event wins over a coincident write-1-to-clear
                r_cmpf[i] <= (r_cmpf[i] && !(w_wr_stat[i] && PWDATA[0])) || w_match[i];
                r_ovff[i] <= (r_ovff[i] && !(w_wr_stat[i] && PWDATA[1])) || w_wrap[i];
            end
        end
    end

    // Combinational read mux, zero outside a valid read access phase
    always_comb begin
        PRDATA = '0;
        for (int i = 0; i < N_TIMERS; i++) begin
            if (w_rd && (w_chan == 4'(i))) begin
                case (w_reg)
                    REG_COUNT: PRDATA = 32'(r_count[i]);
                    REG_CTRL:  PRDATA = {16'h0, r_presc[i], 4'h0, r_ie_ovf[i],
                                         r_ie_cmp[i], r_oneshot[i], r_en[i]};
                    REG_CMP:   PRDATA = 32'(r_cmp[i]);
                    default:   PRDATA = {30'h0, r_ovff[i], r_cmpf[i]};
                endcase
            end
        end
    end

    assign PSLVERR = w_access && !w_chan_ok;
    assign PREADY  = 1'b1;
    assign irq_o   = (r_cmpf & r_ie_cmp) | (r_ovff & r_ie_ovf);

endmodule
